// File: rtl/mips_loader_dump_if.sv
// rtl/mips_loader_dump_if.sv - load, core-control and dump signal bundle for mips_loader_dump
interface mips_loader_dump_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_run;
  logic              cpu_halted;
  logic [4:0]        reg_raddr;
  logic [31:0]       reg_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [1:0]        error;

  modport master (
    input  start, in_valid, in_data, in_last, cpu_halted, reg_rdata, out_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_run, reg_raddr,
           out_valid, out_data, out_last, busy, done, error
  );

  modport slave (
    output start, in_valid, in_data, in_last, cpu_halted, reg_rdata, out_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_run, reg_raddr,
           out_valid, out_data, out_last, busy, done, error
  );
endinterface

// File: rtl/mips_loader_dump.sv
// rtl/mips_loader_dump.sv - program loader, run supervisor and register dump for the MIPS32 core
// Writes a word stream from address 0, runs the core until HLT or timeout, then streams R0..NREGS-1.
module mips_loader_dump #(
  parameter int MEM_DEPTH   = 1024,
  parameter int ADDR_W      = 10,
  parameter int NREGS       = 32,
  parameter int RUN_TIMEOUT = 0
) (
  input  logic               clk1,
  input  logic               rst_n,
  mips_loader_dump_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [5:0]        idx_q, idx_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_run_q, cpu_run_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              done_q, done_d;
  logic [1:0]        error_q, error_d;
  logic              hs;
  logic              timeout;

  assign hs      = (state_q == S_LOAD) && bus.in_valid;
  assign timeout = (RUN_TIMEOUT != 0) && (cnt_q == 32'(RUN_TIMEOUT));

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          done_d  = 1'b0;
          error_d = 2'b00;
          wptr_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (hs) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wptr_q;
          mem_wdata_d = bus.in_data;
          wptr_d      = wptr_q + ADDR_W'(1);
          if (bus.in_last) begin
            state_d = S_RUN;
          end else if (wptr_q == ADDR_W'(MEM_DEPTH - 1)) begin
            // Memory full with no end marker: abandon the session without running the core.
            error_d[0] = 1'b1;
            done_d     = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 32'd1;
        if (bus.cpu_halted) begin
          state_d = S_DUMP;
        end else if (timeout) begin
          error_d[1] = 1'b1;
          state_d    = S_DUMP;
        end
      end
      S_DUMP: begin
        if (out_valid_q && bus.out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end else if (!out_valid_q || bus.out_ready) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.reg_rdata;
          out_last_d  = (idx_q == 6'(NREGS - 1));
          idx_d       = idx_q + 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // One cycle behind the RUN state so the final memory write lands before the core fetches.
    cpu_run_d = (state_q == S_RUN) && (state_d == S_RUN);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      error_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_run_q   <= cpu_run_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.busy      = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DUMP);
  assign bus.reg_raddr = (state_q == S_DUMP) ? idx_q[4:0] : 5'd0;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_run   = cpu_run_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
endmodule
